// File: rtl/cmp_pkg.sv
// Shared types and constants for the digit-serial magnitude comparator.
package cmp_pkg;

  localparam int unsigned DIGIT_W = 2;

  typedef enum logic [1:0] {
    IDLE,
    COMPARE,
    DONE
  } state_e;

endpackage

// File: rtl/agtb2.sv
// 2-bit unsigned greater-than comparator used for one digit pair per cycle.
module agtb2
  import cmp_pkg::*;
(
  input  logic [DIGIT_W-1:0] a,
  input  logic [DIGIT_W-1:0] b,
  output logic               agtb
);

  assign agtb = (a > b);

endmodule

// File: rtl/digit_cmp_seq.sv
// Sequential unsigned magnitude comparator: one 2-bit digit per clock, MSB first,
// stopping on the first unequal digit, with a start/done handshake.
module digit_cmp_seq
  import cmp_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             done,
  output logic             agtb,
  output logic             aeqb,
  output logic             altb
);

  localparam int unsigned NDIG  = WIDTH / DIGIT_W;
  localparam int unsigned CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;

  if ((WIDTH < 2) || ((WIDTH % 2) != 0)) begin : g_width_check
    $error("digit_cmp_seq: WIDTH must be even and >= 2");
  end

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     sa_q, sa_d;
  logic [WIDTH-1:0]     sb_q, sb_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 done_q, done_d;
  logic                 agtb_q, agtb_d;
  logic                 aeqb_q, aeqb_d;
  logic                 altb_q, altb_d;

  logic [DIGIT_W-1:0]   da, db;
  logic                 dig_gt;
  logic                 dig_eq;

  // Current digit pair is always the top of the shift registers.
  assign da     = sa_q[WIDTH-1 -: DIGIT_W];
  assign db     = sb_q[WIDTH-1 -: DIGIT_W];
  assign dig_eq = (da == db);

  agtb2 u_agtb2 (
    .a    (da),
    .b    (db),
    .agtb (dig_gt)
  );

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      agtb_q  <= 1'b0;
      aeqb_q  <= 1'b0;
      altb_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      agtb_q  <= agtb_d;
      aeqb_q  <= aeqb_d;
      altb_q  <= altb_d;
    end
  end

  // Next-state and registered-output logic; done_d is raised on every edge into DONE.
  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    agtb_d  = agtb_q;
    aeqb_d  = aeqb_q;
    altb_d  = altb_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          sa_d    = a;
          sb_d    = b;
          cnt_d   = CNT_W'(NDIG - 1);
          state_d = COMPARE;
        end
      end

      COMPARE: begin
        if (!dig_eq) begin
          agtb_d  = dig_gt;
          altb_d  = !dig_gt;
          aeqb_d  = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end else if (cnt_q == '0) begin
          agtb_d  = 1'b0;
          altb_d  = 1'b0;
          aeqb_d  = 1'b1;
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          sa_d    = sa_q << DIGIT_W;
          sb_d    = sb_q << DIGIT_W;
          cnt_d   = cnt_q - CNT_W'(1);
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign ready = (state_q == IDLE);
  assign done  = done_q;
  assign agtb  = agtb_q;
  assign aeqb  = aeqb_q;
  assign altb  = altb_q;

endmodule

// File: tb/tb_digit_cmp_seq.sv
// Randomized and directed checks of digit_cmp_seq (WIDTH=8 and WIDTH=2) against a behavioural model.
module tb_digit_cmp_seq;

  logic       clk;
  logic       reset_n;
  logic       start8, start2;
  logic [7:0] a8, b8;
  logic [1:0] a2, b2;
  logic       ready8, done8, agtb8, aeqb8, altb8;
  logic       ready2, done2, agtb2_o, aeqb2, altb2;

  int n_vec = 0;
  int n_err = 0;

  digit_cmp_seq #(.WIDTH(8)) u_dut8 (
    .clk(clk), .reset_n(reset_n), .start(start8), .a(a8), .b(b8),
    .ready(ready8), .done(done8), .agtb(agtb8), .aeqb(aeqb8), .altb(altb8)
  );

  digit_cmp_seq #(.WIDTH(2)) u_dut2 (
    .clk(clk), .reset_n(reset_n), .start(start2), .a(a2), .b(b2),
    .ready(ready2), .done(done2), .agtb(agtb2_o), .aeqb(aeqb2), .altb(altb2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // {ready, done, agtb, aeqb, altb} of the selected instance
  function automatic logic [4:0] outs(input bit sel);
    if (sel) return {ready2, done2, agtb2_o, aeqb2, altb2};
    return {ready8, done8, agtb8, aeqb8, altb8};
  endfunction

  // Number of digits examined: position of first differing digit from the top, else all.
  function automatic int ref_k(input logic [7:0] x, input logic [7:0] y, input int w);
    for (int i = w / 2 - 1; i >= 0; i--) begin
      if (((x >> (2 * i)) & 8'd3) != ((y >> (2 * i)) & 8'd3)) return w / 2 - i;
    end
    return w / 2;
  endfunction

  function automatic logic [2:0] ref_res(input logic [7:0] x, input logic [7:0] y);
    return {x > y, x == y, x < y};
  endfunction

  task automatic drive(input bit sel, input logic [7:0] aa, input logic [7:0] bb, input logic st);
    if (sel) begin
      a2 = aa[1:0]; b2 = bb[1:0]; start2 = st;
    end else begin
      a8 = aa; b8 = bb; start8 = st;
    end
  endtask

  task automatic wait_ready(input bit sel);
    logic [4:0] o;
    int t = 0;
    o = outs(sel);
    while (o[4] !== 1'b1 && t < 20) begin
      @(posedge clk); #1;
      o = outs(sel);
      t++;
    end
    if (t == 20) check("ready_timeout", 32'(o[4]), 32'd1);
  endtask

  // One compare; optionally keeps start high with other operands for the first busy cycle.
  task automatic do_op(input bit sel, input logic [7:0] aa, input logic [7:0] bb,
                       input bit garbage, input logic [7:0] ga, input logic [7:0] gb);
    int w;
    int k;
    logic [4:0] o;
    logic [2:0] exp_r;
    w = sel ? 2 : 8;
    k = ref_k(aa, bb, w);
    exp_r = ref_res(aa, bb);
    wait_ready(sel);
    drive(sel, aa, bb, 1'b1);
    @(posedge clk); #1;
    if (garbage) drive(sel, ga, gb, 1'b1);
    else drive(sel, 8'h00, 8'h00, 1'b0);
    for (int n = 1; n <= k + 2; n++) begin
      o = outs(sel);
      check(sel ? "ready2" : "ready8", 32'(o[4]), 32'(n > k + 1));
      check(sel ? "done2" : "done8", 32'(o[3]), 32'(n == k + 1));
      if (n >= k + 1) check(sel ? "result2" : "result8", 32'(o[2:0]), 32'(exp_r));
      if (n == 2) drive(sel, 8'h00, 8'h00, 1'b0);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    logic [7:0] x, y, x2, y2;
    logic [4:0] o;
    int k1, k2;

    reset_n = 1'b0;
    drive(1'b0, 8'h00, 8'h00, 1'b0);
    drive(1'b1, 8'h00, 8'h00, 1'b0);
    #1;
    check("rst8", 32'(outs(1'b0)), 32'h10);
    check("rst2", 32'(outs(1'b1)), 32'h10);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Directed cases
    do_op(1'b0, 8'hA5, 8'hA5, 1'b0, 8'h00, 8'h00);
    do_op(1'b0, 8'h80, 8'h7F, 1'b0, 8'h00, 8'h00);
    do_op(1'b0, 8'h34, 8'h36, 1'b0, 8'h00, 8'h00);
    do_op(1'b0, 8'h10, 8'h20, 1'b1, 8'hFF, 8'h00);

    // Reset in the middle of a compare clears everything with no done pulse
    wait_ready(1'b0);
    drive(1'b0, 8'h55, 8'h55, 1'b1);
    @(posedge clk); #1;
    drive(1'b0, 8'h00, 8'h00, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    check("midrst", 32'(outs(1'b0)), 32'h10);
    @(posedge clk); #1;
    check("midrst_hold", 32'(outs(1'b0)), 32'h10);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst", 32'(outs(1'b0)), 32'h10);
    do_op(1'b0, 8'h01, 8'h00, 1'b0, 8'h00, 8'h00);

    // Start held high across two operations: second accept on first ready edge
    x = 8'hC3; y = 8'hC1; x2 = 8'h0F; y2 = 8'h0F;
    k1 = ref_k(x, y, 8); k2 = ref_k(x2, y2, 8);
    wait_ready(1'b0);
    drive(1'b0, x, y, 1'b1);
    @(posedge clk); #1;
    drive(1'b0, x2, y2, 1'b1);
    for (int n = 1; n <= k1 + k2 + 3; n++) begin
      o = outs(1'b0);
      check("b2b_done", 32'(o[3]), 32'((n == k1 + 1) || (n == k1 + k2 + 3)));
      if (n == k1 + 1) check("b2b_res1", 32'(o[2:0]), 32'(ref_res(x, y)));
      if (n == k1 + k2 + 3) check("b2b_res2", 32'(o[2:0]), 32'(ref_res(x2, y2)));
      if (n == k1 + 3) drive(1'b0, 8'h00, 8'h00, 1'b0);
      @(posedge clk); #1;
    end

    // Randomized operands, biased toward long equal prefixes
    for (int i = 0; i < 40; i++) begin
      x = 8'($urandom);
      case ($urandom_range(0, 2))
        0: y = 8'($urandom);
        1: y = x;
        default: y = x ^ 8'(8'($urandom_range(1, 3)) << (2 * $urandom_range(0, 3)));
      endcase
      do_op(1'b0, x, y, bit'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
    end

    // WIDTH=2: every operand pair
    for (int i = 0; i < 16; i++) begin
      do_op(1'b1, 8'(i / 4), 8'(i % 4), 1'b0, 8'h00, 8'h00);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
